// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
//   state_t : FSM states, sequenced FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH,
//             plus ERROR, which is terminal until reset.
//   class_t : instruction class, latched at the fetch handshake.
//   OP_*    : RV32-style major opcodes recognised by the decoder.
//   ALUOP_* : ALU operation classes driven on alu_op.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERROR  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_ST  = 3'd3,
    C_BR  = 3'd4,
    C_BAD = 3'd5
  } class_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier.
//   opcode   : in  OPCODE_W  major opcode of the fetched instruction
//   op_class : out class_t   instruction class; C_BAD for anything unrecognised
module ctrl_opcode_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic [OPCODE_W-1:0] opcode,
  output class_t              op_class
);

  always_comb begin
    op_class = C_BAD;
    if      (opcode == OPCODE_W'(OP_R))  op_class = C_R;
    else if (opcode == OPCODE_W'(OP_I))  op_class = C_I;
    else if (opcode == OPCODE_W'(OP_LD)) op_class = C_LD;
    else if (opcode == OPCODE_W'(OP_ST)) op_class = C_ST;
    else if (opcode == OPCODE_W'(OP_BR)) op_class = C_BR;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction and data memory, and drives the datapath strobes.
//   clk, rst          : clock; synchronous active-high reset
//   imem_req/_ready   : instruction fetch handshake; opcode is sampled with imem_ready
//   opcode            : opcode of the fetched instruction
//   dmem_ready        : data access complete
//   ir_write/pc_write : IR load and PC update strobes
//   branch, mem_read, mem_write, mem_to_reg, alu_op, alu_src, reg_write : datapath controls
//   illegal_op/timeout: sticky error flags, cleared only by rst
//   dbg_state         : current FSM state (state_t encoding) for observation
//
// Handshake: a request (imem_req in FETCH, mem_read/mem_write in MEM) stays asserted every
// cycle until the matching ready is sampled high on a rising edge; that edge completes the
// transfer and the request drops in the next state. Ready while no request is pending is ignored.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic               dmem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_write,
  output logic               illegal_op,
  output logic               timeout,
  output logic [2:0]         dbg_state
);

  // A zero limit disables the timeout; keep the counter one bit wide so it still elaborates.
  localparam int               CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit               TO_EN     = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  class_t           dec_class;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             in_wait;
  logic             wait_ready;
  logic             limit_hit;

  ctrl_opcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  // Next-state, class latch, sticky flags and wait counter.
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    in_wait    = 1'b0;
    wait_ready = 1'b0;
    cnt_inc    = cnt_q + 1'b1;

    case (state_q)
      FETCH: begin
        in_wait    = 1'b1;
        wait_ready = imem_ready;
        if (imem_ready) begin
          class_d = dec_class;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (class_q == C_BAD) begin
          state_d   = ERROR;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (class_q)
          C_LD, C_ST: state_d = MEM;
          C_BR:       state_d = FETCH;
          default:    state_d = WB;
        endcase
      end
      MEM: begin
        in_wait    = 1'b1;
        wait_ready = dmem_ready;
        if (dmem_ready) state_d = (class_q == C_LD) ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase

    // The limit only fires when ready is still low, so a ready on the last allowed cycle wins.
    limit_hit = TO_EN && in_wait && !wait_ready && (cnt_inc == CNT_LIMIT);
    if (limit_hit) begin
      state_d   = ERROR;
      timeout_d = 1'b1;
    end

    if (state_d != state_q)                  cnt_d = '0;
    else if (TO_EN && in_wait && !wait_ready) cnt_d = cnt_inc;
    else                                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      class_q   <= C_R;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore decode of the registered state and class. The only input-dependent outputs are
  // ir_write/pc_write, which follow imem_ready during FETCH.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALUOP_W'(ALUOP_ADD);
    alu_src    = 1'b0;
    reg_write  = 1'b0;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      EXEC: begin
        case (class_q)
          C_R: alu_op = ALUOP_W'(ALUOP_FUNCT);
          C_I: begin
            alu_op  = ALUOP_W'(ALUOP_FUNCT);
            alu_src = 1'b1;
          end
          C_LD, C_ST: begin
            alu_op  = ALUOP_W'(ALUOP_ADD);
            alu_src = 1'b1;
          end
          C_BR: begin
            alu_op   = ALUOP_W'(ALUOP_SUB);
            branch   = 1'b1;
            pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_read  = (class_q == C_LD);
        mem_write = (class_q == C_ST);
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == C_LD);
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised scoreboard bench for multicycle_control_unit. Each instruction is expanded into
// its cycle-by-cycle output timeline from the latency/strobe table; the driver pushes each
// expected output vector as it drives that cycle, and an independent monitor pops and compares
// at the falling edge.
module tb_multicycle_control_unit;
  import ctrl_pkg::*;

  localparam int TO = 4;
  localparam int W  = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       ir_write, pc_write, branch, mem_read, mem_write, mem_to_reg;
  logic [1:0] alu_op;
  logic       alu_src, reg_write, illegal_op, timeout;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPCODE_W(7), .ALUOP_W(2), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .opcode     (opcode),
    .dmem_ready (dmem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .illegal_op (illegal_op),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  bit           done     = 1'b0;
  logic [W-1:0] got_v, exp_v;

  // Expected output vector layout:
  // {imem_req, ir_write, pc_write, branch, mem_read, mem_write, mem_to_reg,
  //  alu_op[1:0], alu_src, reg_write, illegal_op, timeout, state[2:0]}
  function automatic logic [W-1:0] ev(input state_t st, input logic req, input logic irw,
                                      input logic pcw, input logic br, input logic mr,
                                      input logic mw, input logic m2r, input logic [1:0] aop,
                                      input logic asrc, input logic rw, input logic ill,
                                      input logic to);
    return {req, irw, pcw, br, mr, mw, m2r, aop, asrc, rw, ill, to, st};
  endfunction

  // Reference classification straight from the opcode table: 0 R, 1 I, 2 LD, 3 ST, 4 BR, 5 bad.
  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom_range(0, 127));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic ir, input logic [6:0] op, input logic dr, input logic [W-1:0] e);
    imem_ready = ir;
    opcode     = op;
    dmem_ready = dr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One reset cycle; outputs during it reflect the aborted state and are not checked.
  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = rb();
    dmem_ready = rb();
    opcode     = rop();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ERROR is terminal: strobes stay low whatever the inputs do, flags held, until reset.
  task automatic error_phase(input logic ill, input logic to);
    int n;
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++)
      step(rb(), rop(), rb(), ev(ERROR, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, ill, to));
    do_reset();
  endtask

  // f: low-ready cycles before the fetch handshake (f == TO times out).
  // m: low-ready cycles in MEM (m == TO times out). abort_at: MEM cycle index where rst hits.
  task automatic do_instr(input logic [6:0] op, input int f, input int m, input int abort_at);
    int   k;
    logic is_ld;
    logic [W-1:0] mem_e;
    k     = classify(op);
    is_ld = (k == 2);
    for (int i = 0; i < f; i++)
      step(1'b0, rop(), rb(), ev(FETCH, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    if (f >= TO) begin
      error_phase(1'b0, 1'b1);
      return;
    end
    step(1'b1, op, rb(), ev(FETCH, 1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    step(rb(), rop(), rb(), ev(DECODE, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    if (k == 5) begin
      error_phase(1'b1, 1'b0);
      return;
    end
    case (k)
      0: step(rb(), rop(), rb(), ev(EXEC, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
      1: step(rb(), rop(), rb(), ev(EXEC, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0));
      4: step(rb(), rop(), rb(), ev(EXEC, 0, 0, 1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0));
      default: step(rb(), rop(), rb(), ev(EXEC, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0));
    endcase
    if (k == 4) return;
    if (k == 2 || k == 3) begin
      mem_e = ev(MEM, 0, 0, 0, 0, is_ld, !is_ld, 0, 2'b00, 0, 0, 0, 0);
      for (int i = 0; i < m; i++) begin
        if (i == abort_at) begin
          do_reset();
          return;
        end
        step(rb(), rop(), 1'b0, mem_e);
      end
      if (m >= TO) begin
        error_phase(1'b0, 1'b1);
        return;
      end
      step(rb(), rop(), 1'b1, mem_e);
      if (k == 3) return;
    end
    step(rb(), rop(), rb(), ev(WB, 0, 0, 0, 0, 0, 0, is_ld, 2'b00, 0, 1, 0, 0));
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && !done) begin
        got_v = {imem_req, ir_write, pc_write, branch, mem_read, mem_write, mem_to_reg,
                 alu_op, alu_src, reg_write, illegal_op, timeout, dbg_state};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL underflow cycle %0d: got=%h with no expected entry", cyc, got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL outputs cycle %0d: got=%h exp=%h", cyc, got_v, exp_v);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] legal_ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

  initial begin
    int         sel, f, m, ab;
    logic [6:0] op;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    opcode     = '0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed scenarios.
    do_instr(7'b0110011, 0, 0, -1);        // R-type, zero wait
    do_instr(7'b0000011, 0, 3, -1);        // LD, dmem_ready after 3 low cycles
    do_instr(7'b0100011, 0, 0, -1);        // ST then BR back-to-back
    do_instr(7'b1100011, 0, 0, -1);
    do_instr(7'b1111111, 0, 0, -1);        // illegal opcode
    do_instr(7'b0110011, TO, 0, -1);       // fetch timeout
    do_instr(7'b0110011, TO - 1, 0, -1);   // ready on the last allowed cycle
    do_instr(7'b0000011, 0, TO, -1);       // MEM timeout
    do_instr(7'b0100011, 0, TO - 1, -1);   // MEM ready on the last allowed cycle
    do_instr(7'b0000011, 0, 3, 2);         // reset during LD MEM
    do_instr(7'b0010011, 1, 0, -1);        // I-type after the abort

    // Randomised instruction stream.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 5);
      if (sel < 5) op = legal_ops[sel];
      else begin
        op = rop();
        while (classify(op) != 5) op = rop();
      end
      f  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      m  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, TO - 1) : -1;
      do_instr(op, f, m, ab);
    end

    done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover: got=%0d unconsumed entries exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
